gshare_branch_predictor: RTL and testbench

Parametrised next-generation fetch-stage branch predictor. It pairs a tagged, direct-mapped branch target buffer (BTB) with a separate pattern history table (PHT) of 2-bit saturating counters, indexed either bimodally or by gshare (PC XOR global history). Lookup is combinational in the fetch stage. Training happens one cycle after resolution, from a registered update port driven by execute. Saturating branch and mispredict counters give performance visibility.

---
 rtl/gshare_branch_predictor_if.sv | 32 +++
 rtl/gshare_branch_predictor.sv | 103 ++++++++++
 tb/tb_gshare_branch_predictor.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the gshare branch predictor.
// upd_valid qualifies all upd_* fields for one cycle; there is no ready, every valid update is taken.
interface gshare_branch_predictor_if #(
   parameter int DATA_WIDTH = 32,
   parameter int GHR_BITS   = 8,
   parameter int CNT_WIDTH  = 32
);
   logic [DATA_WIDTH-1:0] RD;
   logic [DATA_WIDTH-1:0] PC_f;
   logic                  predict_taken;
   logic [DATA_WIDTH-1:0] branch_target;
   logic [GHR_BITS-1:0]   pred_ghr;
   logic                  upd_valid;
   logic [DATA_WIDTH-1:0] upd_pc;
   logic                  upd_is_jal;
   logic                  upd_taken;
   logic [DATA_WIDTH-1:0] upd_target;
   logic [GHR_BITS-1:0]   upd_ghr;
   logic                  upd_mispredict;
   logic [CNT_WIDTH-1:0]  branch_count;
   logic [CNT_WIDTH-1:0]  mispredict_count;

   modport master (
      output RD, PC_f, upd_valid, upd_pc, upd_is_jal, upd_taken, upd_target, upd_ghr, upd_mispredict,
      input  predict_taken, branch_target, pred_ghr, branch_count, mispredict_count
   );

   modport slave (
      input  RD, PC_f, upd_valid, upd_pc, upd_is_jal, upd_taken, upd_target, upd_ghr, upd_mispredict,
      output predict_taken, branch_target, pred_ghr, branch_count, mispredict_count
   );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Direct-mapped tagged BTB plus a 2-bit counter PHT (bimodal or gshare indexed).
// Lookup is combinational; training is registered with no bypass into the same-cycle lookup.
module gshare_branch_predictor #(
   parameter int DATA_WIDTH   = 32,
   parameter int BTB_ROWS     = 16,
   parameter int PHT_IDX_BITS = 8,
   parameter int GHR_BITS     = 8,
   parameter int PRED_MODE    = 1,
   parameter int CNT_WIDTH    = 32
) (
   input logic clk,
   input logic rst,
   gshare_branch_predictor_if.slave bus
);
   localparam int BI          = $clog2(BTB_ROWS);
   localparam int TAG_W       = DATA_WIDTH - BI - 2;
   localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;
   localparam bit USE_GHR     = (PRED_MODE != 0);

   typedef struct packed {
      logic                  valid;
      logic [TAG_W-1:0]      tag;
      logic [DATA_WIDTH-1:0] target;
      logic                  is_jal;
   } btb_entry_t;

   btb_entry_t            btb [BTB_ROWS];
   logic [1:0]            pht [PHT_ENTRIES];
   logic [GHR_BITS-1:0]   ghr;
   logic [GHR_BITS-1:0]   ghr_shift;
   logic [CNT_WIDTH-1:0]  br_cnt;
   logic [CNT_WIDTH-1:0]  mp_cnt;

   logic [BI-1:0]           f_idx;
   logic [TAG_W-1:0]        f_tag;
   logic [PHT_IDX_BITS-1:0] f_pht_idx;
   logic [BI-1:0]           u_idx;
   logic [TAG_W-1:0]        u_tag;
   logic [PHT_IDX_BITS-1:0] u_pht_idx;
   logic [PHT_IDX_BITS-1:0] f_hist;
   logic [PHT_IDX_BITS-1:0] u_hist;
   logic                    is_br;
   logic                    is_j;
   logic                    hit;
   logic                    taken;
   logic [1:0]              u_ctr;

   // Bimodal mode still keeps the GHR running; it just stays out of the index.
   assign f_hist = USE_GHR ? PHT_IDX_BITS'(ghr) : '0;
   assign u_hist = USE_GHR ? PHT_IDX_BITS'(bus.upd_ghr) : '0;

   assign f_idx     = bus.PC_f[BI+1:2];
   assign f_tag     = bus.PC_f[DATA_WIDTH-1:BI+2];
   assign f_pht_idx = bus.PC_f[PHT_IDX_BITS+1:2] ^ f_hist;
   assign u_idx     = bus.upd_pc[BI+1:2];
   assign u_tag     = bus.upd_pc[DATA_WIDTH-1:BI+2];
   assign u_pht_idx = bus.upd_pc[PHT_IDX_BITS+1:2] ^ u_hist;
   assign u_ctr     = pht[u_pht_idx];

   assign is_br = (bus.RD[6:0] == 7'b1100011);
   assign is_j  = (bus.RD[6:0] == 7'b1101111);
   assign hit   = btb[f_idx].valid && (btb[f_idx].tag == f_tag);
   assign taken = hit && (is_j ? btb[f_idx].is_jal : (is_br && pht[f_pht_idx][1]));

   assign bus.predict_taken    = taken;
   assign bus.branch_target    = taken ? btb[f_idx].target : bus.PC_f + DATA_WIDTH'(4);
   assign bus.pred_ghr         = ghr;
   assign bus.branch_count     = br_cnt;
   assign bus.mispredict_count = mp_cnt;

   generate
      if (GHR_BITS == 1) begin : g_ghr1
         assign ghr_shift = bus.upd_taken;
      end else begin : g_ghrn
         assign ghr_shift = {ghr[GHR_BITS-2:0], bus.upd_taken};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < BTB_ROWS; i++) btb[i].valid <= 1'b0;
         for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b10;
         ghr    <= '0;
         br_cnt <= '0;
         mp_cnt <= '0;
      end else if (bus.upd_valid) begin
         if (bus.upd_taken)
            btb[u_idx] <= btb_entry_t'{valid: 1'b1, tag: u_tag, target: bus.upd_target,
                                        is_jal: bus.upd_is_jal};
         if (!bus.upd_is_jal) begin
            if (bus.upd_taken && u_ctr != 2'b11) pht[u_pht_idx] <= u_ctr + 2'd1;
            else if (!bus.upd_taken && u_ctr != 2'b00) pht[u_pht_idx] <= u_ctr - 2'd1;
            ghr <= ghr_shift;
         end
         if (br_cnt != '1) br_cnt <= br_cnt + CNT_WIDTH'(1);
         if (bus.upd_mispredict && mp_cnt != '1) mp_cnt <= mp_cnt + CNT_WIDTH'(1);
      end
   end

   // Opcode-only decode and word-aligned PCs leave these bits without a reader.
   logic unused_bits;
   assign unused_bits = ^{bus.RD[DATA_WIDTH-1:7], bus.upd_pc[1:0]};
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor: a gshare instance and a bimodal instance share stimulus.
module tb_gshare_branch_predictor;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] JAL  = 32'h008000ef;
   localparam logic [31:0] ADDI = 32'h00100093;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gshare_branch_predictor_if #(.DATA_WIDTH(32), .GHR_BITS(8), .CNT_WIDTH(8)) bus_g ();
   gshare_branch_predictor_if #(.DATA_WIDTH(32), .GHR_BITS(8), .CNT_WIDTH(4)) bus_b ();

   gshare_branch_predictor #(.DATA_WIDTH(32), .BTB_ROWS(16), .PHT_IDX_BITS(8), .GHR_BITS(8),
                             .PRED_MODE(1), .CNT_WIDTH(8)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));
   gshare_branch_predictor #(.DATA_WIDTH(32), .BTB_ROWS(16), .PHT_IDX_BITS(8), .GHR_BITS(8),
                             .PRED_MODE(0), .CNT_WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int n_vec = 0;
   int n_err = 0;

   // current stimulus
   logic [31:0] cur_rd, cur_pc, cur_upc, cur_utgt;
   logic [7:0]  cur_ughr;
   bit          cur_uv, cur_ujal, cur_ut, cur_umis;

   // reference model: index 0 = gshare instance, 1 = bimodal instance
   bit          mv   [2][16];
   logic [31:0] mtag [2][16];
   logic [31:0] mtgt [2][16];
   bit          mjal [2][16];
   int          mpht [2][256];
   int          mghr [2];
   int          mbc  [2];
   int          mmc  [2];

   typedef struct {
      logic [31:0] rd, pc;
      bit          uv;
      logic [31:0] upc;
      bit          ujal, ut;
      logic [31:0] utgt;
      logic [7:0]  ughr;
      bit          umis;
      bit          exp_taken;
      logic [31:0] exp_tgt;
      logic [7:0]  exp_ghr;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] rd, input logic [31:0] pc, input bit uv,
                        input logic [31:0] upc, input bit ujal, input bit ut,
                        input logic [31:0] utgt, input logic [7:0] ughr, input bit umis);
      cur_rd = rd; cur_pc = pc; cur_uv = uv; cur_upc = upc; cur_ujal = ujal;
      cur_ut = ut; cur_utgt = utgt; cur_ughr = ughr; cur_umis = umis;
      bus_g.RD = rd; bus_g.PC_f = pc; bus_g.upd_valid = uv; bus_g.upd_pc = upc;
      bus_g.upd_is_jal = ujal; bus_g.upd_taken = ut; bus_g.upd_target = utgt;
      bus_g.upd_ghr = ughr; bus_g.upd_mispredict = umis;
      bus_b.RD = rd; bus_b.PC_f = pc; bus_b.upd_valid = uv; bus_b.upd_pc = upc;
      bus_b.upd_is_jal = ujal; bus_b.upd_taken = ut; bus_b.upd_target = utgt;
      bus_b.upd_ghr = ughr; bus_b.upd_mispredict = umis;
   endtask

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) mv[m][i] = 1'b0;
         for (int i = 0; i < 256; i++) mpht[m][i] = 2;
         mghr[m] = 0; mbc[m] = 0; mmc[m] = 0;
      end
   endfunction

   function automatic void mpredict(input int m, input logic [31:0] pc, input logic [31:0] rd,
                                    output bit tk, output logic [31:0] tgt);
      int bi, pi, op;
      bit hit;
      bi  = int'((pc / 4) % 16);
      pi  = int'((pc / 4) % 256) ^ ((m == 0) ? mghr[m] : 0);
      op  = int'(rd % 128);
      hit = mv[m][bi] && (mtag[m][bi] == pc / 64);
      tk  = hit && ((op == 'h6f) ? mjal[m][bi] : (op == 'h63 && mpht[m][pi] >= 2));
      tgt = tk ? mtgt[m][bi] : pc + 32'd4;
   endfunction

   function automatic void mupdate(input int m);
      int bi, pi, cmax;
      cmax = (m == 0) ? 255 : 15;
      if (!cur_uv) return;
      bi = int'((cur_upc / 4) % 16);
      pi = int'((cur_upc / 4) % 256) ^ ((m == 0) ? int'(cur_ughr) : 0);
      if (cur_ut) begin
         mv[m][bi] = 1'b1; mtag[m][bi] = cur_upc / 64; mtgt[m][bi] = cur_utgt; mjal[m][bi] = cur_ujal;
      end
      if (!cur_ujal) begin
         if (cur_ut) mpht[m][pi] = (mpht[m][pi] == 3) ? 3 : mpht[m][pi] + 1;
         else        mpht[m][pi] = (mpht[m][pi] == 0) ? 0 : mpht[m][pi] - 1;
         mghr[m] = (mghr[m] * 2 + int'(cur_ut)) % 256;
      end
      if (mbc[m] < cmax) mbc[m]++;
      if (cur_umis && mmc[m] < cmax) mmc[m]++;
   endfunction

   // Called at the negedge: compare both instances to the model, then advance the model.
   task automatic model_step();
      bit tk;
      logic [31:0] tgt;
      mpredict(0, cur_pc, cur_rd, tk, tgt);
      chk("g_taken", {31'd0, bus_g.predict_taken}, {31'd0, tk});
      chk("g_target", bus_g.branch_target, tgt);
      chk("g_ghr", {24'd0, bus_g.pred_ghr}, mghr[0]);
      chk("g_bcount", {24'd0, bus_g.branch_count}, mbc[0]);
      chk("g_mcount", {24'd0, bus_g.mispredict_count}, mmc[0]);
      mpredict(1, cur_pc, cur_rd, tk, tgt);
      chk("b_taken", {31'd0, bus_b.predict_taken}, {31'd0, tk});
      chk("b_target", bus_b.branch_target, tgt);
      chk("b_ghr", {24'd0, bus_b.pred_ghr}, mghr[1]);
      chk("b_bcount", {28'd0, bus_b.branch_count}, mbc[1]);
      chk("b_mcount", {28'd0, bus_b.mispredict_count}, mmc[1]);
      mupdate(0);
      mupdate(1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic [31:0] rd, input logic [31:0] pc);
      drive(rd, pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
      @(negedge clk);
      model_step();
   endtask

   task automatic upd_cycle(input logic [31:0] upc, input bit ujal, input bit ut,
                            input logic [31:0] utgt, input bit umis);
      drive(ADDI, upc, 1'b1, upc, ujal, ut, utgt, 8'(mghr[0]), umis);
      @(negedge clk);
      model_step();
   endtask

   // Reset held for n cycles with an update pending, which must be dropped.
   task automatic do_reset(input int n);
      drive(BEQ, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h1234, 8'h00, 1'b1);
      rst = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic add(input logic [31:0] rd, input logic [31:0] pc, input bit uv,
                      input logic [31:0] upc, input bit ujal, input bit ut,
                      input logic [31:0] utgt, input logic [7:0] ughr, input bit umis,
                      input bit et, input logic [31:0] etgt, input logic [7:0] eghr);
      vec_t v;
      v.rd = rd; v.pc = pc; v.uv = uv; v.upc = upc; v.ujal = ujal; v.ut = ut;
      v.utgt = utgt; v.ughr = ughr; v.umis = umis;
      v.exp_taken = et; v.exp_tgt = etgt; v.exp_ghr = eghr;
      tbl.push_back(v);
   endtask

   initial begin
      // lookup (rd, pc) | update (valid, pc, jal, taken, target, ghr, mispredict) | expected (gshare)
      add(BEQ,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h104, 8'h00);
      add(BEQ,  32'h100, 1, 32'h100, 0, 1, 32'h80,  8'h00, 1,  0, 32'h104, 8'h00);
      add(BEQ,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  1, 32'h80,  8'h01);
      add(JAL,  32'h200, 1, 32'h200, 1, 1, 32'h400, 8'h01, 1,  0, 32'h204, 8'h01);
      add(JAL,  32'h200, 0, 0,       0, 0, 0,       8'h00, 0,  1, 32'h400, 8'h01);
      add(ADDI, 32'h200, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h204, 8'h01);
      add(JAL,  32'h200, 1, 32'h100, 0, 1, 32'h80,  8'h01, 0,  1, 32'h400, 8'h01);
      add(JAL,  32'h200, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h204, 8'h03);
      add(JAL,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h104, 8'h03);
      add(BEQ,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  1, 32'h80,  8'h03);
      add(BEQ,  32'h100, 1, 32'h100, 0, 0, 32'h0,   8'h03, 1,  1, 32'h80,  8'h03);
      add(BEQ,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  1, 32'h80,  8'h06);
      add(ADDI, 32'hFFFFFFFC, 0, 0,  0, 0, 0,       8'h00, 0,  0, 32'h0,   8'h06);
      add(BEQ,  32'h500, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h504, 8'h06);
      add(BEQ,  32'h100, 1, 32'h500, 0, 1, 32'h900, 8'h06, 0,  1, 32'h80,  8'h06);
      add(BEQ,  32'h100, 0, 0,       0, 0, 0,       8'h00, 0,  0, 32'h104, 8'h0D);
      add(BEQ,  32'h500, 0, 0,       0, 0, 0,       8'h00, 0,  1, 32'h900, 8'h0D);

      drive(ADDI, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      foreach (tbl[i]) begin
         drive(tbl[i].rd, tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ujal, tbl[i].ut,
               tbl[i].utgt, tbl[i].ughr, tbl[i].umis);
         @(negedge clk);
         chk($sformatf("tbl%0d_taken", i), {31'd0, bus_g.predict_taken}, {31'd0, tbl[i].exp_taken});
         chk($sformatf("tbl%0d_target", i), bus_g.branch_target, tbl[i].exp_tgt);
         chk($sformatf("tbl%0d_ghr", i), {24'd0, bus_g.pred_ghr}, {24'd0, tbl[i].exp_ghr});
         model_step();
      end

      // bimodal counter walk at 0x40: taken, three not-taken, then two taken
      upd_cycle(32'h40, 1'b0, 1'b1, 32'h20, 1'b0);
      repeat (3) upd_cycle(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(BEQ, 32'h40, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("bim_nt_taken", {31'd0, bus_b.predict_taken}, 32'd0);
      chk("bim_nt_target", bus_b.branch_target, 32'h44);
      model_step();
      repeat (2) upd_cycle(32'h40, 1'b0, 1'b1, 32'h20, 1'b0);
      drive(BEQ, 32'h40, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("bim_t_taken", {31'd0, bus_b.predict_taken}, 32'd1);
      chk("bim_t_target", bus_b.branch_target, 32'h20);
      model_step();

      // reset with a pending update, then counter saturation and a one-cycle reset
      do_reset(2);
      drive(BEQ, 32'h40, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
      @(negedge clk);
      chk("rst_taken", {31'd0, bus_b.predict_taken}, 32'd0);
      chk("rst_target", bus_g.branch_target, 32'h44);
      chk("rst_ghr", {24'd0, bus_g.pred_ghr}, 32'd0);
      chk("rst_bcount", {24'd0, bus_g.branch_count}, 32'd0);
      model_step();
      for (int i = 0; i < 20; i++) upd_cycle(32'h300 + 32'(i * 4), 1'(i % 3 == 0), 1'(i % 2), 32'h600, 1'b1);
      @(negedge clk);
      chk("sat_bcount", {28'd0, bus_b.branch_count}, 32'hF);
      chk("sat_mcount", {28'd0, bus_b.mispredict_count}, 32'hF);
      chk("g_bcount20", {24'd0, bus_g.branch_count}, 32'd20);
      @(posedge clk);
      #1;
      do_reset(1);
      @(negedge clk);
      chk("clr_bcount", {28'd0, bus_b.branch_count}, 32'd0);
      chk("clr_mcount", {28'd0, bus_b.mispredict_count}, 32'd0);
      model_step();

      // randomized traffic with a small PC pool so hits, aliases and saturation all occur
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] pc, upc, rd;
         int sel;
         bit ujal;
         if (c == 1000) do_reset(1);
         pc  = 32'($urandom_range(0, 3) * 32'h400 + $urandom_range(0, 31) * 4);
         upc = 32'($urandom_range(0, 3) * 32'h400 + $urandom_range(0, 31) * 4);
         sel = $urandom_range(0, 2);
         rd  = ($urandom & 32'hFFFFFF80) | ((sel == 0) ? 32'h63 : (sel == 1) ? 32'h6f : 32'h13);
         ujal = ($urandom_range(0, 3) == 0);
         drive(rd, pc, 1'($urandom_range(0, 1)), upc, ujal, ujal ? 1'b1 : 1'($urandom_range(0, 1)),
               $urandom & 32'hFFFFFFFC, 8'($urandom), 1'($urandom_range(0, 1)));
         @(negedge clk);
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
